// File: rtl/instruction_cache_ctrl_pkg.sv
// Shared field widths and FSM state encoding for the instruction cache controller.
package instruction_cache_ctrl_pkg;

    localparam int OFFSET_W        = 4;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_INDEX_W     = 3;
    localparam int DEF_BLOCK_W     = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = DEF_BLOCK_W / WORD_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_e;

endpackage

// File: rtl/icache_word_select.sv
// Combinational block-to-word mux; word 0 is the least significant 32 bits of the block.
module icache_word_select #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32,
    parameter int SEL_W   = $clog2(BLOCK_W / WORD_W)
) (
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WORD_W-1:0]  word_o
);

    always_comb begin
        word_o = block_i[sel_i*WORD_W +: WORD_W];
    end

endmodule

// File: rtl/instruction_cache_ctrl.sv
// Direct-mapped instruction cache with a single-block fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instruction_cache_ctrl
    import instruction_cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int BLOCK_W = DEF_BLOCK_W,
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     read,
    output logic [WORD_W-1:0]        readinst,
    output logic                     busywait,
    output logic                     mem_read,
    output logic [TAG_W+INDEX_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]       mem_readinst,
    input  logic                     mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
`endif
);

    localparam int NUM_BLOCKS = 1 << INDEX_W;
    localparam int SEL_W      = $clog2(BLOCK_W / WORD_W);

    state_e                 state_q;
    logic                   mem_read_q;
    logic                   first_q;
    logic [TAG_W-1:0]       tag_lat_q;
    logic [INDEX_W-1:0]     index_lat_q;
    logic [NUM_BLOCKS-1:0]  valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]     data_q [NUM_BLOCKS];

    logic [TAG_W-1:0]       tag;
    logic [INDEX_W-1:0]     index;
    logic [SEL_W-1:0]       wsel;
    logic                   hit;
    logic                   unused_addr_bits;

    assign tag              = address[ADDR_W-1 -: TAG_W];
    assign index            = address[OFFSET_W +: INDEX_W];
    assign wsel             = address[OFFSET_W-1 -: SEL_W];
    assign unused_addr_bits = ^address[OFFSET_W-SEL_W-1:0];

    assign hit         = read & valid_q[index] & (tag_q[index] == tag);
    assign mem_read    = mem_read_q;
    assign mem_address = {tag_lat_q, index_lat_q};

    always_comb begin
        busywait = 1'b1;
        if (state_q == S_IDLE) begin
            busywait = read & ~hit;
        end
    end

    icache_word_select #(
        .BLOCK_W (BLOCK_W),
        .WORD_W  (WORD_W)
    ) u_word_select (
        .block_i (data_q[index]),
        .sel_i   (wsel),
        .word_o  (readinst)
    );

    // first_q holds off the exit check for one edge so the memory has time to raise busywait.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            first_q     <= 1'b0;
            tag_lat_q   <= '0;
            index_lat_q <= '0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (read && !hit) begin
                        tag_lat_q   <= tag;
                        index_lat_q <= index;
                        mem_read_q  <= 1'b1;
                        first_q     <= 1'b1;
                        state_q     <= S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (!mem_busywait) begin
                        mem_read_q <= 1'b0;
                        state_q    <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    valid_q[index_lat_q] <= 1'b1;
                    state_q              <= S_IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    first_q    <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (state_q == S_UPDATE) begin
            data_q[index_lat_q] <= mem_readinst;
            tag_q[index_lat_q]  <= tag_lat_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == S_IDLE && read) begin
            if (hit) begin
                if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache_ctrl.sv
// Directed self-checking bench for instruction_cache_ctrl with a small block-memory responder.
module tb_instruction_cache_ctrl;

    logic         clock;
    logic         reset_n;
    logic [9:0]   address;
    logic         read;
    logic [31:0]  readinst;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [127:0] memArray [64];
    logic         memServed;
    int           memCnt;

    instruction_cache_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (address),
        .read         (read),
        .readinst     (readinst),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_readinst = memArray[mem_address];

    // Memory answers a request with three busy cycles, then waits for mem_read to drop.
    always @(posedge clock) begin
        if (!mem_read) begin
            mem_busywait <= 1'b0;
            memServed    <= 1'b0;
        end else if (!memServed && !mem_busywait) begin
            mem_busywait <= 1'b1;
            memCnt       <= 3;
        end else if (mem_busywait) begin
            if (memCnt == 1) begin
                mem_busywait <= 1'b0;
                memServed    <= 1'b1;
            end
            memCnt <= memCnt - 1;
        end
    end

    task automatic waitFill(input string name);
        int cycles = 0;
        while (busywait !== 1'b0 && cycles < 50) begin
            @(negedge clock);
            cycles++;
        end
        total++;
        if (busywait !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s fill timeout: busywait=%b required 0", name, busywait);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        read    = 1'b0;
        address = 10'h000;
        #12;
        total++;
        if (mem_read !== 1'b0 || busywait !== 1'b0 || mem_address !== 6'h00) begin
            bad++;
            $display("[TB] FAIL reset_state: mem_read=%b busywait=%b mem_address=%h required 0 0 00",
                     mem_read, busywait, mem_address);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_first_miss();
        @(negedge clock);
        read    = 1'b1;
        address = 10'h000;
        #1;
        total++;
        if (busywait !== 1'b1 || mem_read !== 1'b0) begin
            bad++;
            $display("[TB] FAIL miss_comb_busy: busywait=%b mem_read=%b required 1 0", busywait, mem_read);
        end
        @(posedge clock); #1;
        total++;
        if (mem_read !== 1'b1 || mem_address !== 6'h00) begin
            bad++;
            $display("[TB] FAIL miss_request: mem_read=%b mem_address=%h required 1 00", mem_read, mem_address);
        end
        waitFill("first_miss");
        total++;
        if (readinst !== 32'h00040019) begin
            bad++;
            $display("[TB] FAIL first_miss_data: readinst=%h required 00040019", readinst);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_hits();
        logic [9:0]  addrs [3] = '{10'h004, 10'h008, 10'h00C};
        logic [31:0] exps  [3] = '{32'h00050023, 32'h02060405, 32'h0001005A};
        for (int i = 0; i < 3; i++) begin
            address = addrs[i];
            #1;
            total++;
            if (busywait !== 1'b0 || mem_read !== 1'b0 || readinst !== exps[i]) begin
                bad++;
                $display("[TB] FAIL hit_%0d: busywait=%b mem_read=%b readinst=%h required 0 0 %h",
                         i, busywait, mem_read, readinst, exps[i]);
            end
            @(posedge clock); #1;
        end
`ifdef ICACHE_STATS_EN
        total++;
        if (hit_count !== 16'd4 || miss_count !== 16'd1) begin
            bad++;
            $display("[TB] FAIL stats: hit_count=%0d miss_count=%0d required 4 1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_conflict();
        address = 10'h080;
        #1;
        total++;
        if (busywait !== 1'b1) begin
            bad++;
            $display("[TB] FAIL conflict_busy: busywait=%b required 1", busywait);
        end
        @(posedge clock); #1;
        total++;
        if (mem_address !== 6'h08 || mem_read !== 1'b1) begin
            bad++;
            $display("[TB] FAIL conflict_addr: mem_address=%h mem_read=%b required 08 1", mem_address, mem_read);
        end
        waitFill("conflict");
        total++;
        if (readinst !== 32'hC0DE0800) begin
            bad++;
            $display("[TB] FAIL conflict_data: readinst=%h required c0de0800", readinst);
        end
        address = 10'h000;
        #1;
        total++;
        if (busywait !== 1'b1) begin
            bad++;
            $display("[TB] FAIL evicted_busy: busywait=%b required 1", busywait);
        end
        @(posedge clock); #1;
        total++;
        if (mem_address !== 6'h00) begin
            bad++;
            $display("[TB] FAIL evicted_addr: mem_address=%h required 00", mem_address);
        end
        waitFill("evicted");
        total++;
        if (readinst !== 32'h00040019) begin
            bad++;
            $display("[TB] FAIL evicted_data: readinst=%h required 00040019", readinst);
        end
    endtask

    task automatic test_addr_change();
        address = 10'h01C;
        @(posedge clock); #1;
        total++;
        if (mem_address !== 6'h01) begin
            bad++;
            $display("[TB] FAIL latch_addr: mem_address=%h required 01", mem_address);
        end
        address = 10'h3F0;
        @(posedge clock);
        @(posedge clock); #1;
        total++;
        if (mem_address !== 6'h01 || mem_read !== 1'b1 || busywait !== 1'b1) begin
            bad++;
            $display("[TB] FAIL addr_change: mem_address=%h mem_read=%b busywait=%b required 01 1 1",
                     mem_address, mem_read, busywait);
        end
        address = 10'h01C;
        waitFill("addr_change");
        total++;
        if (readinst !== 32'hC0DE0103) begin
            bad++;
            $display("[TB] FAIL addr_change_data: readinst=%h required c0de0103", readinst);
        end
    endtask

    task automatic test_reset_mid_fill();
        address = 10'h020;
        @(posedge clock); #1;
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_start: mem_read=%b required 1", mem_read);
        end
        @(negedge clock);
        read    = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if (mem_read !== 1'b0 || busywait !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort: mem_read=%b busywait=%b required 0 0", mem_read, busywait);
        end
        @(negedge clock);
        reset_n = 1'b1;
        read    = 1'b1;
        address = 10'h020;
        #1;
        total++;
        if (busywait !== 1'b1) begin
            bad++;
            $display("[TB] FAIL refetch_busy: busywait=%b required 1", busywait);
        end
        @(posedge clock); #1;
        total++;
        if (mem_read !== 1'b1 || mem_address !== 6'h02) begin
            bad++;
            $display("[TB] FAIL refetch_req: mem_read=%b mem_address=%h required 1 02", mem_read, mem_address);
        end
        waitFill("refetch");
        total++;
        if (readinst !== 32'hC0DE0200) begin
            bad++;
            $display("[TB] FAIL refetch_data: readinst=%h required c0de0200", readinst);
        end
    endtask

    task automatic test_no_read();
        read    = 1'b0;
        address = 10'h3F0;
        #1;
        total++;
        if (busywait !== 1'b0 || mem_read !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_comb: busywait=%b mem_read=%b required 0 0", busywait, mem_read);
        end
        @(posedge clock); #1;
        total++;
        if (busywait !== 1'b0 || mem_read !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_hold: busywait=%b mem_read=%b required 0 0", busywait, mem_read);
        end
    endtask

    task automatic test_read_drop();
        read    = 1'b1;
        address = 10'h3F0;
        @(posedge clock); #1;
        read = 1'b0;
        #1;
        total++;
        if (busywait !== 1'b1 || mem_read !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drop_busy: busywait=%b mem_read=%b required 1 1", busywait, mem_read);
        end
        waitFill("read_drop");
        read = 1'b1;
        #1;
        total++;
        if (busywait !== 1'b0 || readinst !== 32'hC0DE3F00) begin
            bad++;
            $display("[TB] FAIL drop_installed: busywait=%b readinst=%h required 0 c0de3f00", busywait, readinst);
        end
        read = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            for (int w = 0; w < 4; w++) begin
                memArray[i][w*32 +: 32] = {16'hC0DE, 8'(i), 8'(w)};
            end
        end
        memArray[0] = {32'h0001005A, 32'h02060405, 32'h00050023, 32'h00040019};

        test_reset();
        test_first_miss();
        test_hits();
        test_conflict();
        test_addr_change();
        test_reset_mid_fill();
        test_no_read();
        test_read_drop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
